dispatcher: RTL and testbench

Single-entry dispatch stage between the instruction decoder and the three reservation stations (ALURS, LSB, BranchRS). It owns the transmit side of the RS dispatch bundle. For each decoded instruction it:
- resolves source operands from the register file, the ROB and the four CDBs;
- allocates a ROB tag and renames `rd`;
- pushes the instruction to the target station only when that station and the ROB both have room.

It holds one instruction and can issue one instruction per cycle.

---
 rtl/dispatcher_pkg.sv | 17 +
 rtl/dispatcher_operand_resolve.sv | 56 +++++
 rtl/dispatcher.sv | 204 ++++++++++++++++++++
 tb/tb_dispatcher.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared widths, instruction-class encodings and state type for the dispatch stage.
package dispatcher_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned OP_W   = 6;

   localparam logic [1:0] CLS_ALU = 2'd0;
   localparam logic [1:0] CLS_LSB = 2'd1;
   localparam logic [1:0] CLS_BR  = 2'd2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/dispatcher_operand_resolve.sv
// Resolves one source operand: x0/unused, register file, ROB, then the four CDBs
// (index 0 = ALU, 1 = LSB, 2 = Branch, 3 = ROB), else waits on the rf tag.
module operand_resolve #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 4
) (
   input  logic                   use_i,
   input  logic [4:0]             reg_i,
   input  logic                   rf_busy_i,
   input  logic [DATA_W-1:0]      rf_data_i,
   input  logic [TAG_W-1:0]       rf_tag_i,
   input  logic                   rob_ready_i,
   input  logic [DATA_W-1:0]      rob_data_i,
   input  logic [3:0]             cdb_valid_i,
   input  logic [3:0][TAG_W-1:0]  cdb_tag_i,
   input  logic [3:0][DATA_W-1:0] cdb_data_i,
   output logic                   valid_o,
   output logic [DATA_W-1:0]      data_o,
   output logic [TAG_W-1:0]       tag_o
);

   logic              hit;
   logic [DATA_W-1:0] hit_data;

   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!hit && cdb_valid_i[i] && (cdb_tag_i[i] == rf_tag_i)) begin
            hit      = 1'b1;
            hit_data = cdb_data_i[i];
         end
      end
   end

   always_comb begin
      valid_o = 1'b0;
      data_o  = '0;
      tag_o   = '0;
      if (!use_i || (reg_i == 5'd0)) begin
         valid_o = 1'b1;
      end else if (!rf_busy_i) begin
         valid_o = 1'b1;
         data_o  = rf_data_i;
      end else if (rob_ready_i) begin
         valid_o = 1'b1;
         data_o  = rob_data_i;
      end else if (hit) begin
         valid_o = 1'b1;
         data_o  = hit_data;
      end else begin
         tag_o   = rf_tag_i;
      end
   end

endmodule

// File: rtl/dispatcher.sv
// Single-entry dispatch stage: holds one decoded instruction, resolves its operands,
// allocates a ROB tag, renames rd and pushes it to ALURS, LSB or BranchRS.
module dispatcher #(
   parameter int unsigned DATA_W = dispatcher_pkg::DATA_W,
   parameter int unsigned TAG_W  = dispatcher_pkg::TAG_W,
   parameter int unsigned OP_W   = dispatcher_pkg::OP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic              id_valid,
   input  logic [OP_W-1:0]   id_op,
   input  logic [1:0]        id_class,
   input  logic [4:0]        id_rd,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc,
   output logic              id_ready,
   output logic [4:0]        rf_q1_addr,
   output logic [4:0]        rf_q2_addr,
   input  logic              rf_q1_busy,
   input  logic [DATA_W-1:0] rf_q1_data,
   input  logic [TAG_W-1:0]  rf_q1_tag,
   input  logic              rf_q2_busy,
   input  logic [DATA_W-1:0] rf_q2_data,
   input  logic [TAG_W-1:0]  rf_q2_tag,
   output logic [TAG_W-1:0]  rob_q1_tag,
   output logic [TAG_W-1:0]  rob_q2_tag,
   input  logic              rob_q1_ready,
   input  logic [DATA_W-1:0] rob_q1_data,
   input  logic              rob_q2_ready,
   input  logic [DATA_W-1:0] rob_q2_data,
   input  logic              rob_full,
   input  logic [TAG_W-1:0]  rob_free_tag,
   output logic              rob_alloc_valid,
   output logic [OP_W-1:0]   rob_alloc_op,
   output logic [4:0]        rob_alloc_rd,
   output logic [DATA_W-1:0] rob_alloc_pc,
   output logic              rename_valid,
   output logic [4:0]        rename_rd,
   output logic [TAG_W-1:0]  rename_tag,
   input  logic              alurs_full,
   input  logic              lsb_full,
   input  logic              brrs_full,
   output logic              alurs_valid,
   output logic              lsb_valid,
   output logic              brrs_valid,
   output logic [OP_W-1:0]   dispatch_op,
   output logic [DATA_W-1:0] dispatch_imm,
   output logic [DATA_W-1:0] dispatch_pc,
   output logic              dispatch_reg1_valid,
   output logic [DATA_W-1:0] dispatch_reg1_data,
   output logic [TAG_W-1:0]  dispatch_reg1_tag,
   output logic              dispatch_reg2_valid,
   output logic [DATA_W-1:0] dispatch_reg2_data,
   output logic [TAG_W-1:0]  dispatch_reg2_tag,
   output logic [TAG_W-1:0]  dispatch_reg_dest_tag,
   input  logic              ALU_cdb_valid,
   input  logic [TAG_W-1:0]  ALU_cdb_tag,
   input  logic [DATA_W-1:0] ALU_cdb_data,
   input  logic              LSB_cdb_valid,
   input  logic [TAG_W-1:0]  LSB_cdb_tag,
   input  logic [DATA_W-1:0] LSB_cdb_data,
   input  logic              Branch_cdb_valid,
   input  logic [TAG_W-1:0]  Branch_cdb_tag,
   input  logic [DATA_W-1:0] Branch_cdb_data,
   input  logic              ROB_cdb_valid,
   input  logic [TAG_W-1:0]  ROB_cdb_tag,
   input  logic [DATA_W-1:0] ROB_cdb_data
);

   import dispatcher_pkg::*;

   state_e            state_q;
   logic [OP_W-1:0]   op_q;
   logic [1:0]        cls_q;
   logic [4:0]        rd_q, rs1_q, rs2_q;
   logic              use1_q, use2_q;
   logic [DATA_W-1:0] imm_q, pc_q;

   logic                   st_full, go, accept;
   logic [3:0]             cdb_valid;
   logic [3:0][TAG_W-1:0]  cdb_tag;
   logic [3:0][DATA_W-1:0] cdb_data;
   logic                   r1_valid, r2_valid;
   logic [DATA_W-1:0]      r1_data, r2_data;
   logic [TAG_W-1:0]       r1_tag, r2_tag;

   assign cdb_valid = {ROB_cdb_valid, Branch_cdb_valid, LSB_cdb_valid, ALU_cdb_valid};
   assign cdb_tag   = {ROB_cdb_tag, Branch_cdb_tag, LSB_cdb_tag, ALU_cdb_tag};
   assign cdb_data  = {ROB_cdb_data, Branch_cdb_data, LSB_cdb_data, ALU_cdb_data};

   always_comb begin
      case (cls_q)
         CLS_LSB: st_full = lsb_full;
         CLS_BR:  st_full = brrs_full;
         default: st_full = alurs_full;
      endcase
   end

   assign go       = (state_q == ST_HOLD) && rdy && !clear && !rob_full && !st_full;
   assign id_ready = rdy && ((state_q == ST_EMPTY) || go);
   assign accept   = id_valid && id_ready && !clear;

   assign rf_q1_addr = rs1_q;
   assign rf_q2_addr = rs2_q;
   assign rob_q1_tag = rf_q1_tag;
   assign rob_q2_tag = rf_q2_tag;

   operand_resolve #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_res1 (
      .use_i(use1_q), .reg_i(rs1_q), .rf_busy_i(rf_q1_busy), .rf_data_i(rf_q1_data),
      .rf_tag_i(rf_q1_tag), .rob_ready_i(rob_q1_ready), .rob_data_i(rob_q1_data),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
      .valid_o(r1_valid), .data_o(r1_data), .tag_o(r1_tag)
   );

   operand_resolve #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_res2 (
      .use_i(use2_q), .reg_i(rs2_q), .rf_busy_i(rf_q2_busy), .rf_data_i(rf_q2_data),
      .rf_tag_i(rf_q2_tag), .rob_ready_i(rob_q2_ready), .rob_data_i(rob_q2_data),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
      .valid_o(r2_valid), .data_o(r2_data), .tag_o(r2_tag)
   );

   // A same-edge accept refills the hold register, so HOLD wins over EMPTY.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q <= ST_EMPTY;
         op_q    <= '0;
         cls_q   <= CLS_ALU;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         use1_q  <= 1'b0;
         use2_q  <= 1'b0;
         imm_q   <= '0;
         pc_q    <= '0;
      end else if (accept) begin
         state_q <= ST_HOLD;
         op_q    <= id_op;
         cls_q   <= id_class;
         rd_q    <= id_rd;
         rs1_q   <= id_rs1;
         rs2_q   <= id_rs2;
         use1_q  <= id_use_rs1;
         use2_q  <= id_use_rs2;
         imm_q   <= id_imm;
         pc_q    <= id_pc;
      end else if (go) begin
         state_q <= ST_EMPTY;
      end
   end

   always_comb begin
      alurs_valid           = 1'b0;
      lsb_valid             = 1'b0;
      brrs_valid            = 1'b0;
      rob_alloc_valid       = 1'b0;
      rob_alloc_op          = '0;
      rob_alloc_rd          = '0;
      rob_alloc_pc          = '0;
      rename_valid          = 1'b0;
      rename_rd             = '0;
      rename_tag            = '0;
      dispatch_op           = '0;
      dispatch_imm          = '0;
      dispatch_pc           = '0;
      dispatch_reg1_valid   = 1'b0;
      dispatch_reg1_data    = '0;
      dispatch_reg1_tag     = '0;
      dispatch_reg2_valid   = 1'b0;
      dispatch_reg2_data    = '0;
      dispatch_reg2_tag     = '0;
      dispatch_reg_dest_tag = '0;
      if (go) begin
         case (cls_q)
            CLS_LSB: lsb_valid   = 1'b1;
            CLS_BR:  brrs_valid  = 1'b1;
            default: alurs_valid = 1'b1;
         endcase
         rob_alloc_valid       = 1'b1;
         rob_alloc_op          = op_q;
         rob_alloc_rd          = rd_q;
         rob_alloc_pc          = pc_q;
         rename_valid          = (rd_q != 5'd0);
         rename_rd             = rd_q;
         rename_tag            = rob_free_tag;
         dispatch_op           = op_q;
         dispatch_imm          = imm_q;
         dispatch_pc           = pc_q;
         dispatch_reg1_valid   = r1_valid;
         dispatch_reg1_data    = r1_data;
         dispatch_reg1_tag     = r1_tag;
         dispatch_reg2_valid   = r2_valid;
         dispatch_reg2_data    = r2_data;
         dispatch_reg2_tag     = r2_tag;
         dispatch_reg_dest_tag = rob_free_tag;
      end
   end

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for the dispatch stage: vector table for operand resolution plus
// hand sequences for reset, stall, rdy, clear and a back-to-back RAW stream.
module tb_dispatcher;

   logic        clk = 1'b0;
   logic        rst, rdy, clear;
   logic        id_valid;
   logic [5:0]  id_op;
   logic [1:0]  id_class;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic        id_use_rs1, id_use_rs2;
   logic [31:0] id_imm, id_pc;
   logic        id_ready;
   logic [4:0]  rf_q1_addr, rf_q2_addr;
   logic        rf_q1_busy, rf_q2_busy;
   logic [31:0] rf_q1_data, rf_q2_data;
   logic [3:0]  rf_q1_tag, rf_q2_tag;
   logic [3:0]  rob_q1_tag, rob_q2_tag;
   logic        rob_q1_ready, rob_q2_ready;
   logic [31:0] rob_q1_data, rob_q2_data;
   logic        rob_full;
   logic [3:0]  rob_free_tag;
   logic        rob_alloc_valid;
   logic [5:0]  rob_alloc_op;
   logic [4:0]  rob_alloc_rd;
   logic [31:0] rob_alloc_pc;
   logic        rename_valid;
   logic [4:0]  rename_rd;
   logic [3:0]  rename_tag;
   logic        alurs_full, lsb_full, brrs_full;
   logic        alurs_valid, lsb_valid, brrs_valid;
   logic [5:0]  dispatch_op;
   logic [31:0] dispatch_imm, dispatch_pc;
   logic        dispatch_reg1_valid, dispatch_reg2_valid;
   logic [31:0] dispatch_reg1_data, dispatch_reg2_data;
   logic [3:0]  dispatch_reg1_tag, dispatch_reg2_tag, dispatch_reg_dest_tag;
   logic        ALU_cdb_valid, LSB_cdb_valid, Branch_cdb_valid, ROB_cdb_valid;
   logic [3:0]  ALU_cdb_tag, LSB_cdb_tag, Branch_cdb_tag, ROB_cdb_tag;
   logic [31:0] ALU_cdb_data, LSB_cdb_data, Branch_cdb_data, ROB_cdb_data;

   always #5 clk = ~clk;

   dispatcher #(.DATA_W(32), .TAG_W(4), .OP_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .id_valid(id_valid), .id_op(id_op), .id_class(id_class), .id_rd(id_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_imm(id_imm), .id_pc(id_pc), .id_ready(id_ready),
      .rf_q1_addr(rf_q1_addr), .rf_q2_addr(rf_q2_addr),
      .rf_q1_busy(rf_q1_busy), .rf_q1_data(rf_q1_data), .rf_q1_tag(rf_q1_tag),
      .rf_q2_busy(rf_q2_busy), .rf_q2_data(rf_q2_data), .rf_q2_tag(rf_q2_tag),
      .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
      .rob_q1_ready(rob_q1_ready), .rob_q1_data(rob_q1_data),
      .rob_q2_ready(rob_q2_ready), .rob_q2_data(rob_q2_data),
      .rob_full(rob_full), .rob_free_tag(rob_free_tag),
      .rob_alloc_valid(rob_alloc_valid), .rob_alloc_op(rob_alloc_op),
      .rob_alloc_rd(rob_alloc_rd), .rob_alloc_pc(rob_alloc_pc),
      .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_tag(rename_tag),
      .alurs_full(alurs_full), .lsb_full(lsb_full), .brrs_full(brrs_full),
      .alurs_valid(alurs_valid), .lsb_valid(lsb_valid), .brrs_valid(brrs_valid),
      .dispatch_op(dispatch_op), .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc),
      .dispatch_reg1_valid(dispatch_reg1_valid), .dispatch_reg1_data(dispatch_reg1_data),
      .dispatch_reg1_tag(dispatch_reg1_tag),
      .dispatch_reg2_valid(dispatch_reg2_valid), .dispatch_reg2_data(dispatch_reg2_data),
      .dispatch_reg2_tag(dispatch_reg2_tag), .dispatch_reg_dest_tag(dispatch_reg_dest_tag),
      .ALU_cdb_valid(ALU_cdb_valid), .ALU_cdb_tag(ALU_cdb_tag), .ALU_cdb_data(ALU_cdb_data),
      .LSB_cdb_valid(LSB_cdb_valid), .LSB_cdb_tag(LSB_cdb_tag), .LSB_cdb_data(LSB_cdb_data),
      .Branch_cdb_valid(Branch_cdb_valid), .Branch_cdb_tag(Branch_cdb_tag),
      .Branch_cdb_data(Branch_cdb_data),
      .ROB_cdb_valid(ROB_cdb_valid), .ROB_cdb_tag(ROB_cdb_tag), .ROB_cdb_data(ROB_cdb_data)
   );

   // cmask/ctag bit 0 / nibble 0 = ALU bus, then LSB, Branch, ROB; bus i carries cbase+i.
   // e_stb = {brrs, lsb, alurs}.
   typedef struct {
      logic [5:0]  op;   logic [1:0] cls; logic [4:0] rd, rs1, rs2; logic u1, u2;
      logic [31:0] imm, pc;
      logic b1; logic [31:0] d1; logic [3:0] t1; logic rr1; logic [31:0] rd1;
      logic b2; logic [31:0] d2; logic [3:0] t2; logic rr2; logic [31:0] rd2;
      logic [3:0] cmask; logic [15:0] ctag; logic [31:0] cbase; logic [3:0] free;
      logic [2:0] e_stb;
      logic ev1; logic [31:0] ed1; logic [3:0] et1;
      logic ev2; logic [31:0] ed2; logic [3:0] et2;
      logic eren;
   } vec_t;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_env();
      rdy = 1'b1; clear = 1'b0; id_valid = 1'b0;
      rf_q1_busy = 1'b0; rf_q1_data = '0; rf_q1_tag = '0;
      rf_q2_busy = 1'b0; rf_q2_data = '0; rf_q2_tag = '0;
      rob_q1_ready = 1'b0; rob_q1_data = '0; rob_q2_ready = 1'b0; rob_q2_data = '0;
      rob_full = 1'b0; rob_free_tag = '0;
      alurs_full = 1'b0; lsb_full = 1'b0; brrs_full = 1'b0;
      ALU_cdb_valid = 1'b0; ALU_cdb_tag = '0; ALU_cdb_data = '0;
      LSB_cdb_valid = 1'b0; LSB_cdb_tag = '0; LSB_cdb_data = '0;
      Branch_cdb_valid = 1'b0; Branch_cdb_tag = '0; Branch_cdb_data = '0;
      ROB_cdb_valid = 1'b0; ROB_cdb_tag = '0; ROB_cdb_data = '0;
   endtask

   task automatic offer(input logic [5:0] op, input logic [1:0] cls, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [31:0] imm, input logic [31:0] pc);
      id_valid = 1'b1; id_op = op; id_class = cls; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_use_rs1 = u1; id_use_rs2 = u2; id_imm = imm; id_pc = pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_stb"}, {29'd0, brrs_valid, lsb_valid, alurs_valid}, 32'd0);
      chk({name, "_alloc"}, {31'd0, rob_alloc_valid}, 32'd0);
      chk({name, "_ren"}, {31'd0, rename_valid}, 32'd0);
   endtask

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{6'h01, 2'd0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 32'h0, 32'h100,
                  1'b0, 32'd5, 4'd0, 1'b0, 32'h0, 1'b0, 32'd7, 4'd0, 1'b0, 32'h0,
                  4'b0000, 16'h0000, 32'h0, 4'd2, 3'b001,
                  1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1};
      vecs[1] = '{6'h01, 2'd0, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 32'h8, 32'h104,
                  1'b1, 32'hDEAD, 4'd4, 1'b0, 32'h99, 1'b0, 32'h77, 4'd0, 1'b0, 32'h0,
                  4'b0001, 16'h0004, 32'h10, 4'd5, 3'b001,
                  1'b1, 32'h10, 4'd0, 1'b1, 32'h0, 4'd0, 1'b0};
      vecs[2] = '{6'h23, 2'd1, 5'd0, 5'd6, 5'd0, 1'b1, 1'b1, 32'h4, 32'h108,
                  1'b1, 32'h0, 4'd6, 1'b1, 32'h55, 1'b1, 32'hEE, 4'd3, 1'b1, 32'h66,
                  4'b0000, 16'h0000, 32'h0, 4'd7, 3'b010,
                  1'b1, 32'h55, 4'd0, 1'b1, 32'h0, 4'd0, 1'b0};
      vecs[3] = '{6'h63, 2'd2, 5'd5, 5'd7, 5'd9, 1'b1, 1'b1, 32'h10, 32'h10C,
                  1'b1, 32'h0, 4'd7, 1'b0, 32'h0, 1'b1, 32'h0, 4'd9, 1'b0, 32'h0,
                  4'b1011, 16'h7073, 32'h20, 4'd1, 3'b100,
                  1'b1, 32'h21, 4'd0, 1'b0, 32'h0, 4'd9, 1'b1};
      vecs[4] = '{6'h01, 2'd0, 5'd8, 5'd2, 5'd1, 1'b1, 1'b1, 32'h0, 32'h110,
                  1'b1, 32'h0, 4'd2, 1'b1, 32'h33, 1'b1, 32'h0, 4'd1, 1'b0, 32'h0,
                  4'b1101, 16'h1102, 32'h40, 4'hF, 3'b001,
                  1'b1, 32'h33, 4'd0, 1'b1, 32'h42, 4'd0, 1'b1};
      vecs[5] = '{6'h01, 2'd0, 5'd0, 5'd3, 5'd4, 1'b0, 1'b1, 32'h0, 32'h114,
                  1'b1, 32'h0, 4'd5, 1'b1, 32'hFF, 1'b0, 32'h1234, 4'd5, 1'b0, 32'h0,
                  4'b0001, 16'h0005, 32'h50, 4'd0, 3'b001,
                  1'b1, 32'h0, 4'd0, 1'b1, 32'h1234, 4'd0, 1'b0};
      vecs[6] = '{6'h03, 2'd1, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 32'h20, 32'h118,
                  1'b1, 32'h0, 4'hC, 1'b0, 32'h0, 1'b1, 32'h0, 4'hD, 1'b0, 32'h0,
                  4'b1000, 16'hC000, 32'h60, 4'hA, 3'b010,
                  1'b1, 32'h63, 4'd0, 1'b0, 32'h0, 4'hD, 1'b1};

      idle_env();
      offer(6'h01, 2'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0; id_valid = 1'b0;
      #1;
      chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
      chk_quiet("rst");
      step();
      #1;
      chk_quiet("rst_after");

      // Vector table: accept, resolve in the dispatch cycle, then confirm EMPTY.
      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         offer(v.op, v.cls, v.rd, v.rs1, v.rs2, v.u1, v.u2, v.imm, v.pc);
         step();
         id_valid = 1'b0;
         rf_q1_busy = v.b1; rf_q1_data = v.d1; rf_q1_tag = v.t1;
         rf_q2_busy = v.b2; rf_q2_data = v.d2; rf_q2_tag = v.t2;
         rob_q1_ready = v.rr1; rob_q1_data = v.rd1; rob_q2_ready = v.rr2; rob_q2_data = v.rd2;
         ALU_cdb_valid = v.cmask[0]; ALU_cdb_tag = v.ctag[3:0]; ALU_cdb_data = v.cbase;
         LSB_cdb_valid = v.cmask[1]; LSB_cdb_tag = v.ctag[7:4]; LSB_cdb_data = v.cbase + 1;
         Branch_cdb_valid = v.cmask[2]; Branch_cdb_tag = v.ctag[11:8];
         Branch_cdb_data = v.cbase + 2;
         ROB_cdb_valid = v.cmask[3]; ROB_cdb_tag = v.ctag[15:12]; ROB_cdb_data = v.cbase + 3;
         rob_free_tag = v.free;
         #1;
         chk($sformatf("v%0d_stb", i), {29'd0, brrs_valid, lsb_valid, alurs_valid},
             {29'd0, v.e_stb});
         chk($sformatf("v%0d_alloc", i), {31'd0, rob_alloc_valid}, 32'd1);
         chk($sformatf("v%0d_qaddr", i), {22'd0, rf_q1_addr, rf_q2_addr}, {22'd0, v.rs1, v.rs2});
         chk($sformatf("v%0d_robq", i), {24'd0, rob_q1_tag, rob_q2_tag}, {24'd0, v.t1, v.t2});
         chk($sformatf("v%0d_r1v", i), {31'd0, dispatch_reg1_valid}, {31'd0, v.ev1});
         chk($sformatf("v%0d_r1d", i), dispatch_reg1_data, v.ed1);
         if (!v.ev1) chk($sformatf("v%0d_r1t", i), {28'd0, dispatch_reg1_tag}, {28'd0, v.et1});
         chk($sformatf("v%0d_r2v", i), {31'd0, dispatch_reg2_valid}, {31'd0, v.ev2});
         chk($sformatf("v%0d_r2d", i), dispatch_reg2_data, v.ed2);
         if (!v.ev2) chk($sformatf("v%0d_r2t", i), {28'd0, dispatch_reg2_tag}, {28'd0, v.et2});
         chk($sformatf("v%0d_dest", i), {28'd0, dispatch_reg_dest_tag}, {28'd0, v.free});
         chk($sformatf("v%0d_ren", i), {31'd0, rename_valid}, {31'd0, v.eren});
         if (v.eren) chk($sformatf("v%0d_rentag", i), {23'd0, rename_rd, rename_tag},
                         {23'd0, v.rd, v.free});
         chk($sformatf("v%0d_bundle", i), {26'd0, dispatch_op}, {26'd0, v.op});
         chk($sformatf("v%0d_pcimm", i), dispatch_pc ^ dispatch_imm, v.pc ^ v.imm);
         chk($sformatf("v%0d_robop", i), {21'd0, rob_alloc_op, rob_alloc_rd},
             {21'd0, v.op, v.rd});
         step();
         idle_env();
         #1;
         chk_quiet($sformatf("v%0d_empty", i));
      end

      // Station-full stall with other stations free, then release with others full.
      offer(6'h01, 2'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h200);
      alurs_full = 1'b1;
      step();
      id_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d_ready", k), {31'd0, id_ready}, 32'd0);
         chk_quiet($sformatf("stall%0d", k));
         step();
      end
      alurs_full = 1'b0; lsb_full = 1'b1; brrs_full = 1'b1; rob_free_tag = 4'd6;
      #1;
      chk("stall_rel_stb", {29'd0, brrs_valid, lsb_valid, alurs_valid}, 32'd1);
      chk("stall_rel_ready", {31'd0, id_ready}, 32'd1);
      chk("stall_rel_ren", {23'd0, rename_rd, rename_tag}, {23'd0, 5'd4, 4'd6});
      step();
      idle_env();

      // rob_full then rdy low, each holding an LSB op.
      offer(6'h03, 2'd1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h300);
      step();
      id_valid = 1'b0; rob_full = 1'b1;
      #1;
      chk_quiet("robfull");
      chk("robfull_ready", {31'd0, id_ready}, 32'd0);
      step();
      rob_full = 1'b0; rdy = 1'b0;
      #1;
      chk_quiet("rdylow");
      chk("rdylow_ready", {31'd0, id_ready}, 32'd0);
      step();
      rdy = 1'b1;
      #1;
      chk("rdyhigh_stb", {29'd0, brrs_valid, lsb_valid, alurs_valid}, 32'd2);
      step();
      idle_env();

      // clear in HOLD with a new instruction offered.
      offer(6'h01, 2'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h400);
      step();
      rob_full = 1'b1;
      offer(6'h63, 2'd2, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h404);
      step();
      rob_full = 1'b0; clear = 1'b1;
      #1;
      chk_quiet("clear");
      step();
      idle_env();
      #1;
      chk("clear_next_ready", {31'd0, id_ready}, 32'd1);
      chk_quiet("clear_next");
      step();
      #1;
      chk_quiet("clear_next2");

      // Stream: ADDI x1; ADD x2,x1,x1; SW x2 at one per cycle.
      offer(6'h13, 2'd0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 32'd5, 32'h500);
      step();
      offer(6'h33, 2'd0, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 32'd0, 32'h504);
      rob_free_tag = 4'd3;
      #1;
      chk("s1_stb", {29'd0, brrs_valid, lsb_valid, alurs_valid}, 32'd1);
      chk("s1_ren", {22'd0, rename_valid, rename_rd, rename_tag}, {22'd0, 1'b1, 5'd1, 4'd3});
      chk("s1_ready", {31'd0, id_ready}, 32'd1);
      step();
      offer(6'h23, 2'd1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 32'd0, 32'h508);
      rf_q1_busy = 1'b1; rf_q1_tag = 4'd3; rf_q2_busy = 1'b1; rf_q2_tag = 4'd3;
      rob_free_tag = 4'd4;
      #1;
      chk("s2_stb", {29'd0, brrs_valid, lsb_valid, alurs_valid}, 32'd1);
      chk("s2_qaddr", {22'd0, rf_q1_addr, rf_q2_addr}, {22'd0, 5'd1, 5'd1});
      chk("s2_r1", {27'd0, dispatch_reg1_valid, dispatch_reg1_tag}, {27'd0, 1'b0, 4'd3});
      chk("s2_r2", {27'd0, dispatch_reg2_valid, dispatch_reg2_tag}, {27'd0, 1'b0, 4'd3});
      chk("s2_ren", {22'd0, rename_valid, rename_rd, rename_tag}, {22'd0, 1'b1, 5'd2, 4'd4});
      chk("s2_ready", {31'd0, id_ready}, 32'd1);
      step();
      id_valid = 1'b0;
      rf_q1_busy = 1'b0; rf_q1_tag = 4'd0; rf_q2_busy = 1'b1; rf_q2_tag = 4'd4;
      rob_free_tag = 4'd5;
      #1;
      chk("s3_stb", {29'd0, brrs_valid, lsb_valid, alurs_valid}, 32'd2);
      chk("s3_r1", {31'd0, dispatch_reg1_valid}, 32'd1);
      chk("s3_r2", {27'd0, dispatch_reg2_valid, dispatch_reg2_tag}, {27'd0, 1'b0, 4'd4});
      chk("s3_ren", {31'd0, rename_valid}, 32'd0);
      chk("s3_dest", {28'd0, dispatch_reg_dest_tag}, 32'd5);
      step();
      idle_env();
      #1;
      chk_quiet("s_end");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
